// File: rtl/frag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : frag_fifo
// Purpose  : Fragment buffer between the bounding-box traverser and the
//            fragment shading stage. Assembles addressed word writes
//            (addr 0 = x, addr 1 = y, addr 2.. = attributes) into whole
//            fragments, holds up to DEPTH of them, and streams them out
//            word by word over a valid/ready interface.
// Ports    : clk, reset (async, active-high)
//            wr_data/wr_addr/wr_en/frag_last  - traverser write side
//            rd_data/rd_addr/rd_last/rd_valid/rd_ready - shader read side
//            ovf_clear                        - clears sticky overflow
//            full/empty/threshold/overflow/underflow - status to traverser
// Revision : 1.0 - initial release
// ============================================================================
module frag_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int THRESHOLD  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] frag_last,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  ovf_clear,
  output logic                  full,
  output logic                  empty,
  output logic                  threshold,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam int                WORDS    = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0]  C_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_THRESH = CNT_W'(THRESHOLD);

  // Fragment storage; contents are don't-care until written.
  logic [DATA_WIDTH-1:0] mem_q  [DEPTH][WORDS];
  logic [ADDR_WIDTH-1:0] last_q [DEPTH];

  logic [PTR_W-1:0]      wptr_q,   wptr_d;
  logic [PTR_W-1:0]      rptr_q,   rptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                  open_q,   open_d;
  logic                  ovf_q,    ovf_d;
  logic                  unf_q,    unf_d;

  logic w_start, w_open_start, w_drop, w_body, w_store, w_commit;
  logic w_is_last, w_pop, w_pop_last;

  // --------------------------------------------------------------------------
  // Write-side decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_start      = wr_en && (wr_addr == '0);
    w_open_start = w_start && !full;
    w_drop       = w_start && full;
    w_body       = wr_en && (wr_addr != '0) && open_q;
    w_store      = w_open_start || w_body;
    // A single-word fragment (frag_last==0) commits on its own addr-0 write.
    w_commit     = (w_open_start && (frag_last == '0)) ||
                   (w_body && (wr_addr == last_q[wptr_q]));
  end

  // --------------------------------------------------------------------------
  // Read-side decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_is_last  = (rd_idx_q == last_q[rptr_q]);
    w_pop      = rd_valid && rd_ready;
    w_pop_last = w_pop && w_is_last;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;
    open_d   = open_q;

    // An addr-0 write while open simply restarts the same slot.
    if (w_open_start) open_d = 1'b1;
    if (w_drop)       open_d = 1'b0;
    if (w_commit) begin
      open_d = 1'b0;
      wptr_d = wptr_q + PTR_W'(1);
    end

    if (w_pop) begin
      if (w_is_last) begin
        rd_idx_d = '0;
        rptr_d   = rptr_q + PTR_W'(1);
      end else begin
        rd_idx_d = rd_idx_q + ADDR_WIDTH'(1);
      end
    end

    // Commit and final pop together leave the count unchanged.
    case ({w_commit, w_pop_last})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins, keeping overflow set.
    ovf_d = w_drop || (ovf_q && !ovf_clear);
    unf_d = rd_ready && (count_q == '0);
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rd_idx_q <= '0;
      open_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      open_q   <= open_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage (no reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_store)      mem_q[wptr_q][wr_addr] <= wr_data;
    if (w_open_start) last_q[wptr_q]         <= frag_last;
  end

  // --------------------------------------------------------------------------
  // Outputs. Data and last are gated by valid so nothing undefined escapes
  // from unwritten storage while the buffer is empty.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_valid  = (count_q != '0);
    rd_data   = rd_valid ? mem_q[rptr_q][rd_idx_q] : '0;
    rd_addr   = rd_idx_q;
    rd_last   = rd_valid && w_is_last;
    full      = (count_q == C_DEPTH);
    empty     = (count_q == '0);
    threshold = (count_q >= C_THRESH);
    overflow  = ovf_q;
    underflow = unf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_frag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_frag_fifo
// Purpose  : Self-checking bench for frag_fifo. A queue-based model of
//            stored fragments predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frag_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int THR   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] frag_last = '0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          rd_last, rd_valid;
  logic          rd_ready = 1'b0;
  logic          ovf_clear = 1'b0;
  logic          full, empty, threshold, overflow, underflow;

  frag_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .THRESHOLD(THR)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .frag_last(frag_last), .rd_data(rd_data), .rd_addr(rd_addr), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .ovf_clear(ovf_clear), .full(full),
    .empty(empty), .threshold(threshold), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: committed fragments as a flat word queue plus lengths.
  logic [DW-1:0] wq[$];
  int            lens[$];
  int            ridx = 0;
  bit            m_open = 0;
  int            m_last = 0;
  logic [DW-1:0] cur[16];
  bit            m_ovf = 0;
  bit            m_unf = 0;

  int rdy_mode = 0;  // 0 low, 1 high, 2 toggle, 3 random
  bit tog = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete(); lens.delete();
    ridx = 0; m_open = 0; m_last = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic check_all();
    bit v;
    logic [DW-1:0] ed;
    int ea;
    bit el;
    v  = (lens.size() != 0);
    ed = '0; ea = 0; el = 0;
    if (v) begin
      ed = wq[ridx]; ea = ridx; el = (ridx == lens[0] - 1);
    end else begin
      ea = ridx;
    end
    chk("rd_valid",  64'(rd_valid),  64'(v));
    chk("rd_data",   64'(rd_data),   64'(ed));
    chk("rd_addr",   64'(rd_addr),   64'(ea));
    chk("rd_last",   64'(rd_last),   64'(el));
    chk("full",      64'(full),      64'(lens.size() == DEPTH));
    chk("empty",     64'(empty),     64'(lens.size() == 0));
    chk("threshold", 64'(threshold), 64'(lens.size() >= THR));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_unf));
  endtask

  task automatic model_step(input bit we, input int a, input logic [DW-1:0] d,
                            input int fl, input bit rr, input bit oc);
    int  pre_size;
    bit  commit, drop;
    pre_size = lens.size();
    commit = 0; drop = 0;
    if (we) begin
      if (a == 0) begin
        if (pre_size == DEPTH) begin
          drop = 1; m_open = 0;
        end else begin
          m_open = 1; m_last = fl; cur[0] = d;
          if (fl == 0) commit = 1;
        end
      end else if (m_open) begin
        cur[a] = d;
        if (a == m_last) commit = 1;
      end
    end
    if (pre_size > 0 && rr) begin
      if (ridx == lens[0] - 1) begin
        repeat (lens[0]) void'(wq.pop_front());
        void'(lens.pop_front());
        ridx = 0;
      end else begin
        ridx++;
      end
    end
    if (commit) begin
      for (int i = 0; i <= m_last; i++) wq.push_back(cur[i]);
      lens.push_back(m_last + 1);
      m_open = 0;
    end
    m_ovf = drop ? 1'b1 : (oc ? 1'b0 : m_ovf);
    m_unf = rr && (pre_size == 0);
  endtask

  // One clock: check pre-edge outputs, drive inputs, advance model, clock.
  task automatic step(input bit we, input int a, input logic [DW-1:0] d,
                      input int fl, input bit oc);
    bit rr;
    @(negedge clk);
    check_all();
    case (rdy_mode)
      0:       rr = 1'b0;
      1:       rr = 1'b1;
      2:       rr = ~tog;
      default: rr = 1'($urandom_range(0, 1));
    endcase
    tog       = rr;
    wr_en     = we;
    wr_addr   = AW'(a);
    wr_data   = d;
    frag_last = AW'(fl);
    rd_ready  = rr;
    ovf_clear = oc;
    model_step(we, a, d, fl, rr, oc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, '0, 0, 1'b0);
  endtask

  task automatic send_frag(input int last, input logic [DW-1:0] base, input bit gaps);
    for (int a = 0; a <= last; a++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle();
      step(1'b1, a, base + DW'(a), last, 1'b0);
    end
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 200 && lens.size() != 0; i++) idle();
    idle();
    chk("drain_empty", 64'(empty), 64'd1);
  endtask

  initial begin
    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data",  64'(rd_data),  64'd0);
    chk("rst_empty", 64'(empty),    64'd1);

    // ---- single fragment ----
    rdy_mode = 1;
    send_frag(4, 32'h10, 1'b0);
    repeat (7) idle();
    chk("single_empty", 64'(empty), 64'd1);

    // ---- fill, overflow, clear ----
    rdy_mode = 0;
    send_frag(2, 32'h100, 1'b0);
    send_frag(2, 32'h200, 1'b0);
    send_frag(2, 32'h300, 1'b0);
    chk("fill_thr",   64'(threshold), 64'd1);
    chk("fill_nfull", 64'(full),      64'd0);
    send_frag(2, 32'h400, 1'b0);
    chk("fill_full",  64'(full),      64'd1);
    send_frag(2, 32'hBAD0, 1'b0);
    chk("ovf_set",    64'(overflow),  64'd1);
    step(1'b0, 0, '0, 0, 1'b1);
    chk("ovf_clr",    64'(overflow),  64'd0);

    // ---- backpressure readout ----
    rdy_mode = 2;
    repeat (30) idle();
    drain();

    // ---- concurrent commit and final pop ----
    rdy_mode = 0;
    send_frag(1, 32'h500, 1'b0);
    step(1'b1, 0, 32'h600, 2, 1'b0);
    rdy_mode = 1;
    step(1'b1, 1, 32'h601, 2, 1'b0);
    step(1'b1, 2, 32'h602, 2, 1'b0);
    rdy_mode = 0;
    chk("conc_valid", 64'(rd_valid), 64'd1);
    chk("conc_data",  64'(rd_data),  64'h600);
    chk("conc_addr",  64'(rd_addr),  64'd0);
    drain();

    // ---- restart then wrap ----
    rdy_mode = 1;
    step(1'b1, 0, 32'hDEAD0, 3, 1'b0);
    step(1'b1, 1, 32'hDEAD1, 3, 1'b0);
    send_frag(3, 32'h700, 1'b0);
    rdy_mode = 3;
    for (int n = 0; n < 10; n++)
      send_frag(int'($urandom_range(0, 5)), $urandom, 1'b1);
    drain();

    // ---- randomized mix ----
    rdy_mode = 3;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: step(1'b1, int'($urandom_range(1, 15)), $urandom, 0, 1'b0);
        1: step(1'b0, 0, '0, 0, 1'($urandom_range(0, 1)));
        2: begin
          int k;
          logic [DW-1:0] b;
          k = int'($urandom_range(1, 4));
          b = $urandom;
          for (int a = 0; a < k; a++) step(1'b1, a, b + DW'(a), 5, 1'b0);
          send_frag(int'($urandom_range(0, 6)), $urandom, 1'b1);
        end
        default: send_frag(int'($urandom_range(0, 6)), $urandom, 1'b1);
      endcase
    end
    drain();

    // ---- reset mid-readout, then underflow ----
    rdy_mode = 0;
    send_frag(2, 32'hA0, 1'b0);
    send_frag(2, 32'hB0, 1'b0);
    rdy_mode = 1;
    idle();
    @(negedge clk);
    wr_en = 1'b0; rd_ready = 1'b0; ovf_clear = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_empty", 64'(empty),    64'd1);
    chk("arst_valid", 64'(rd_valid), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    rdy_mode = 1;
    idle();
    chk("unf_pulse", 64'(underflow), 64'd1);
    rdy_mode = 0;
    idle();
    chk("unf_drop",  64'(underflow), 64'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frag_fifo.md
Name: frag_fifo

Overview:
- Fragment buffer directly downstream of the bounding box traverser.
- Accepts the traverser's addressed word writes: addr 0 = x, addr 1 = y, addr 2..N = interpolated attributes. Assembles them into whole fragments.
- Stores up to DEPTH complete fragments and streams them word-by-word to the fragment shading stage over a valid/ready interface.
- Drives the traverser's full/empty/threshold/overflow/underflow flag inputs.

Parameters:
DATA_WIDTH, 32, width of each fragment word
ADDR_WIDTH, 4, word index width; one slot holds 2^ADDR_WIDTH words
DEPTH, 4, number of fragment slots (power of two, >=2)
THRESHOLD, 3, occupancy at or above which threshold asserts (1..DEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
wr_data  in  DATA_WIDTH  fragment word from traverser
wr_addr  in  ADDR_WIDTH  word index within fragment
wr_en  in  1  write strobe
frag_last  in  ADDR_WIDTH  index of final word of a fragment; sampled on each addr-0 write
rd_data  out  DATA_WIDTH  current output word
rd_addr  out  ADDR_WIDTH  index of current output word
rd_last  out  1  current word is the final word of its fragment
rd_valid  out  1  output word valid
rd_ready  in  1  consumer accepts word
ovf_clear  in  1  clears sticky overflow
full  out  1  count == DEPTH
empty  out  1  count == 0
threshold  out  1  count >= THRESHOLD
overflow  out  1  sticky: fragment dropped because buffer full
underflow  out  1  one-cycle pulse: rd_ready high while empty

Behaviour:
- Reset (asynchronous, active-high):
  - wptr, rptr, count, rd word index and open all go to 0.
  - Outputs after reset: rd_valid=0, rd_last=0, rd_addr=0, rd_data=0, full=0, empty=1, threshold=0, overflow=0, underflow=0.
  - Storage contents are undefined after reset.
  - A reset asserted mid-fragment or mid-readout discards all fragments.
- Write side, evaluated at each clk edge with wr_en=1:
  - wr_addr==0 and not full: open=1. Latch frag_last into the per-slot last register of slot wptr. Store word 0.
  - wr_addr==0 while open: the previous fragment is abandoned and restarts in the same slot; no count change.
  - wr_addr==0 and full: fragment is dropped. overflow<=1, open stays 0, all following writes are ignored until the next addr-0 write.
  - wr_addr!=0 while open: store word at [wptr][wr_addr].
  - Commit: wr_addr equals the latched last index while open. Store the word, then open<=0, wptr<=wptr+1 (wraps mod DEPTH), count increments.
  - Writes while not open (after a drop, or before any addr-0 write) are ignored.
  - frag_last==0 means a single-word fragment: the addr-0 write both opens and commits.
- Read side:
  - rd_valid = (count != 0).
  - rd_data = mem[rptr][rd_idx], rd_addr = rd_idx, rd_last = (rd_idx == slot_last[rptr]). These are combinational from registers.
  - On rd_valid & rd_ready:
    - if not last: rd_idx increments;
    - if last: rd_idx<=0, rptr<=rptr+1 (wraps mod DEPTH), count decrements.
  - rd_data/rd_addr/rd_last must be held stable while rd_valid=1 and rd_ready=0.
- Latency: a fragment committed at edge k gives rd_valid=1 from just after edge k (visible during cycle k+1).
- Simultaneous commit and final pop in the same cycle: count is unchanged; both pointers advance.
- Same-slot hazard: wptr can only equal rptr with an open fragment when count==0. No conflict arises because no slot is being read in that case.
- Flags are combinational from count. underflow is registered: underflow <= rd_ready & (count==0).
- overflow clears on ovf_clear=1. If ovf_clear and a new drop occur in the same cycle, overflow stays 1.
- count width is clog2(DEPTH)+1. count never exceeds DEPTH and never goes below 0.

Test Plan:
- Single fragment: frag_last=4, writes addr0..4 with data 0x10..0x14, rd_ready=1. Required: 5 output words 0x10..0x14 with rd_addr 0..4, rd_last only on addr 4, then empty=1.
- Fill: commit 4 fragments (frag_last=2) with rd_ready=0. Required: threshold=1 after the 3rd, full=1 after the 4th. A 5th addr-0 write sets overflow=1 and its words are never output. ovf_clear then returns overflow to 0.
- Backpressure: toggle rd_ready every cycle during readout. Required: word order preserved, held words stable, no duplicates.
- Concurrent: with count=1, commit a new fragment in the same cycle the final word of the old one is popped. Required: count stays 1 and the next output fragment is the new one.
- Restart and wrap: addr0,addr1 then addr0 again with new data, followed by completion. Required: only the new data is output. Stream 10 fragments through DEPTH=4 so the pointers wrap; order is preserved.
- Reset and underflow: assert reset mid-readout; required: empty=1, rd_valid=0 immediately. Then rd_ready=1 with the buffer empty gives a one-cycle underflow pulse.
